// File: rtl/uart_pkg.sv
// Shared definitions for the UART ports: FSM encoding, default baud divisor and
// status word bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

   // 25 MHz system clock / 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 217;

   localparam int STAT_FULL = 15;
   localparam int STAT_BUSY = 14;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous 8-bit FIFO with first-word-fall-through head output.
// Push when full and pop when empty are ignored.
module uart_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are DEPTH-sized, so the increment wraps modulo DEPTH on its own.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only read once the
   // count says they were written, so clearing them would just cost logic.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: FIFO-buffered writes from the CPU,
// registered status word {full, busy, 11'b0, count} for the read path.
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DEPTH        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] in,
   output logic [15:0] out,
   output logic        tx
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(DEPTH) + 1;

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic          pop;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic          baud_last;

   // Only the low byte is transmitted; the high byte is intentionally dropped.
   logic          unused_in_hi;
   assign unused_in_hi = ^in[15:8];

   uart_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (load),
      .pop   (pop),
      .din   (in[7:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         UART_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               baud_d  = '0;
               state_d = UART_START;
            end
         end
         UART_START: begin
            if (baud_last) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = UART_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         UART_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d = UART_STOP;
               else bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         UART_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  state_d = UART_START;
               end else begin
                  state_d = UART_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = UART_IDLE;
      endcase

      // tx is registered from the next-state view so the line changes on the
      // same edge as the state it belongs to.
      case (state_d)
         UART_START: tx_d = 1'b0;
         UART_DATA:  tx_d = shift_d[0];
         default:    tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UART_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   always_comb begin
      out            = '0;
      out[STAT_FULL] = fifo_full;
      out[STAT_BUSY] = (state_q != UART_IDLE);
      out[2:0]       = 3'(fifo_count);
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus random writes,
// compared every cycle against a timeline model of queued bytes and frame slots.
module tb_uart_tx_port;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        load  = 1'b0;
   logic [15:0] din   = '0;
   logic [15:0] dout;
   logic        tx;

   always #5 clk = ~clk;

   uart_tx_port #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .in    (din),
      .out   (dout),
      .tx    (tx)
   );

   // Model: bytes waiting, and the edge at which the line becomes free again.
   logic [7:0] byte_q[$];
   logic [7:0] cur_byte = '0;
   int         cyc      = 0;
   int         free_at  = 0;
   int         last_pop = 0;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
   endtask

   function automatic logic exp_tx();
      int k;
      if (cyc >= free_at) return 1'b1;
      k = (cyc - last_pop) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return cur_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [15:0] exp_out();
      logic [15:0] s;
      int          n;
      n     = byte_q.size();
      s     = '0;
      s[15] = (n == DEPTH);
      s[14] = (cyc < free_at);
      s[2:0] = 3'(n);
      return s;
   endfunction

   task automatic model_edge(input logic ld, input logic [15:0] d);
      int pre;
      pre = byte_q.size();
      cyc = cyc + 1;
      if (cyc >= free_at && pre > 0) begin
         cur_byte = byte_q.pop_front();
         last_pop = cyc;
         free_at  = cyc + FRAME;
      end
      if (ld && pre < DEPTH) byte_q.push_back(d[7:0]);
   endtask

   task automatic step(input logic ld, input logic [15:0] d);
      load = ld;
      din  = d;
      @(posedge clk);
      model_edge(ld, d);
      #1;
      check("tx", {15'b0, tx}, {15'b0, exp_tx()});
      check("status", dout, exp_out());
      load = 1'b0;
   endtask

   task automatic do_reset(input int hold_edges);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_tx", {15'b0, tx}, 16'h0001);
      check("reset_status", dout, 16'h0000);
      byte_q.delete();
      free_at = cyc;
      repeat (hold_edges) begin
         @(posedge clk);
         cyc = cyc + 1;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Power-on reset.
      #2;
      rst_n = 1'b0;
      #1;
      check("por_tx", {15'b0, tx}, 16'h0001);
      check("por_status", dout, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step(1'b0, '0);

      // Single byte; high byte must be ignored.
      step(1'b1, 16'hFF41);
      check("single_queued", dout, 16'h0001);
      step(1'b0, '0);
      check("single_start_tx", {15'b0, tx}, 16'h0000);
      check("single_popped", dout, 16'h4000);
      repeat (FRAME + 4) step(1'b0, '0);

      // Back-to-back frames.
      step(1'b1, 16'h0055);
      step(1'b1, 16'h00AA);
      check("b2b_status", dout, 16'h4001);
      repeat (2 * FRAME + 4) step(1'b0, '0);

      // Overflow: six consecutive writes, the last one dropped.
      for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom));
      check("overflow_full", dout, 16'hC004);
      // Write on the STOP->START edge while full: rejected, count drops to 3.
      for (int i = 0; i < FRAME && (cyc + 1) != free_at; i++) step(1'b0, '0);
      step(1'b1, 16'h1234);
      check("full_pop_reject", dout, 16'h4003);
      repeat (5 * FRAME + 4) step(1'b0, '0);

      // Reset in the middle of data bit 3.
      step(1'b1, 16'h00C6);
      for (int i = 0; i < FRAME && cyc != last_pop + 4 * CPB + 1; i++) step(1'b0, '0);
      do_reset(2);
      repeat (4) step(1'b0, '0);
      step(1'b1, 16'h000F);
      repeat (FRAME + 4) step(1'b0, '0);

      // Random traffic, with one reset dropped in partway.
      for (int i = 0; i < 900; i++) begin
         step(($urandom_range(0, 5) == 0), 16'($urandom));
         if (i == 450) do_reset(1);
      end
      repeat (5 * FRAME + 4) step(1'b0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
